// File: rtl/sincos_result_pack_pkg.sv
// sincos_result_pack_pkg: shared constants and float types for the fsincos output stage
package sincos_result_pack_pkg;
  localparam int BIAS = 127;
  localparam int EXP_MAX = 255;
  localparam int IFW = 64;
  localparam logic signed [7:0] EXP_ZERO = 8'sh80;
  // internal float; frac is left-aligned in a 64-bit container so any FRAC_WIDTH up to 64 fits
  typedef struct packed {
    logic sign;
    logic signed [7:0] exp;
    logic [IFW-1:0] frac;
  } ifloat_t;
  typedef struct packed {
    logic sign;
    logic [7:0] exp;
    logic [22:0] man;
  } fp32_t;
endpackage

// File: rtl/sincos_result_pack_fp_round_pack.sv
// fp_round_pack: combinational round-to-nearest-even of an internal float into binary32
//   i_op  : internal float (frac left-aligned, MSB = leading one)
//   o_res : binary32 result
//   o_ovf : result saturated to infinity
//   o_uf  : nonzero input flushed to zero
module fp_round_pack
  import sincos_result_pack_pkg::*;
(
  input  ifloat_t     i_op,
  output fp32_t       o_res,
  output logic        o_ovf,
  output logic        o_uf
);
  logic zero, g, st, inc;
  logic [23:0] mr;
  logic signed [9:0] be, be_r;
  always_comb begin
    zero = (i_op.exp == EXP_ZERO) || !i_op.frac[IFW-1];
    be = {{2{i_op.exp[7]}}, i_op.exp} + 10'(BIAS);
    g = i_op.frac[IFW-25];
    st = |i_op.frac[IFW-26:0];
    inc = g & (st | i_op.frac[IFW-24]);
    mr = {1'b0, i_op.frac[IFW-2:IFW-24]} + {23'd0, inc};
    // a mantissa carry-out leaves mr[22:0] all zero, so only the exponent needs bumping
    be_r = be + {9'd0, mr[23]};
    o_uf = !zero && (be_r <= 10'sd0);
    o_ovf = !zero && (be_r >= 10'(EXP_MAX));
    o_res = (zero || o_uf) ? {i_op.sign, 31'd0} :
            o_ovf ? {i_op.sign, 8'hFF, 23'd0} :
            {i_op.sign, be_r[7:0], mr[22:0]};
  end
endmodule

// File: rtl/sincos_result_pack.sv
// sincos_result_pack: two-stage operand select + binary32 round/pack with valid/ready and sticky flags
//   i_clk/i_rstn            : clock, asynchronous active-low reset
//   i_valid/o_ready         : input handshake
//   i_sign_c/i_exp_c/i_frac_c : FMA result
//   i_sign_x/i_exp_x/i_frac_x : bypassed X operand
//   i_X_ZERO_CAL            : select X instead of the FMA result
//   i_RESULT_SIGN_FLIP      : invert the final sign
//   o_valid/i_ready/o_result : output handshake and binary32 result
//   i_flag_clr/o_flag_ovf/o_flag_uf : sticky status
module sincos_result_pack
  import sincos_result_pack_pkg::*;
#(
  parameter int FRAC_WIDTH = 40,
  parameter int EXP_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_sign_c,
  input  logic [EXP_WIDTH-1:0]  i_exp_c,
  input  logic [FRAC_WIDTH-1:0] i_frac_c,
  input  logic                  i_sign_x,
  input  logic [7:0]            i_exp_x,
  input  logic [31:0]           i_frac_x,
  input  logic                  i_X_ZERO_CAL,
  input  logic                  i_RESULT_SIGN_FLIP,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [31:0]           o_result,
  input  logic                  i_flag_clr,
  output logic                  o_flag_ovf,
  output logic                  o_flag_uf
);
  ifloat_t op_in, s1_op_q, s1_op_d;
  fp32_t rp_res;
  logic rp_ovf, rp_uf, s1_adv, acc;
  logic s1_v_q, s1_v_d, o_valid_q, o_valid_d, ovf_q, ovf_d, uf_q, uf_d;
  logic [31:0] o_result_q, o_result_d;
  fp_round_pack u_round (.i_op(s1_op_q), .o_res(rp_res), .o_ovf(rp_ovf), .o_uf(rp_uf));
  always_comb begin
    op_in.sign = (i_X_ZERO_CAL ? i_sign_x : i_sign_c) ^ i_RESULT_SIGN_FLIP;
    op_in.exp = i_X_ZERO_CAL ? i_exp_x : 8'(i_exp_c);
    op_in.frac = i_X_ZERO_CAL ? {i_frac_x, 32'd0} : IFW'(i_frac_c) << (IFW - FRAC_WIDTH);
    s1_adv = s1_v_q && (!o_valid_q || i_ready);
    o_ready = !s1_v_q || s1_adv;
    acc = i_valid && o_ready;
    s1_v_d = acc ? 1'b1 : s1_adv ? 1'b0 : s1_v_q;
    s1_op_d = acc ? op_in : s1_op_q;
    o_valid_d = s1_adv ? 1'b1 : i_ready ? 1'b0 : o_valid_q;
    o_result_d = s1_adv ? rp_res : o_result_q;
    ovf_d = !i_flag_clr && (ovf_q || (s1_adv && rp_ovf));
    uf_d = !i_flag_clr && (uf_q || (s1_adv && rp_uf));
  end
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      s1_v_q <= 1'b0;
      s1_op_q <= '0;
      o_valid_q <= 1'b0;
      o_result_q <= '0;
      ovf_q <= 1'b0;
      uf_q <= 1'b0;
    end else begin
      s1_v_q <= s1_v_d;
      s1_op_q <= s1_op_d;
      o_valid_q <= o_valid_d;
      o_result_q <= o_result_d;
      ovf_q <= ovf_d;
      uf_q <= uf_d;
    end
  end
  assign o_valid = o_valid_q;
  assign o_result = o_result_q;
  assign o_flag_ovf = ovf_q;
  assign o_flag_uf = uf_q;
endmodule

// File: tb/tb_sincos_result_pack.sv
// tb_sincos_result_pack: directed table-driven bench for sincos_result_pack
module tb_sincos_result_pack;
  logic i_clk = 0, i_rstn = 0, i_valid = 0, i_ready = 1, i_flag_clr = 0;
  logic i_sign_c = 0, i_sign_x = 0, i_X_ZERO_CAL = 0, i_RESULT_SIGN_FLIP = 0;
  logic [7:0] i_exp_c = 0, i_exp_x = 0;
  logic [39:0] i_frac_c = 0;
  logic [31:0] i_frac_x = 0;
  logic o_ready, o_valid, o_flag_ovf, o_flag_uf;
  logic [31:0] o_result;
  sincos_result_pack #(.FRAC_WIDTH(40), .EXP_WIDTH(8)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_valid(i_valid), .o_ready(o_ready),
    .i_sign_c(i_sign_c), .i_exp_c(i_exp_c), .i_frac_c(i_frac_c),
    .i_sign_x(i_sign_x), .i_exp_x(i_exp_x), .i_frac_x(i_frac_x),
    .i_X_ZERO_CAL(i_X_ZERO_CAL), .i_RESULT_SIGN_FLIP(i_RESULT_SIGN_FLIP),
    .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
    .i_flag_clr(i_flag_clr), .o_flag_ovf(o_flag_ovf), .o_flag_uf(o_flag_uf)
  );
  always #5 i_clk = ~i_clk;
  typedef struct {
    logic sc; logic [7:0] ec; logic [39:0] fc;
    logic sx; logic [7:0] ex; logic [31:0] fx;
    logic xz; logic fl;
    logic [31:0] res; logic ovf; logic uf;
  } vec_t;
  localparam int NV = 14;
  vec_t vecs[NV];
  vec_t bp[3];
  logic [31:0] got[$];
  logic acc;
  int idx;
  int checks = 0, failures = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic drive(input vec_t v);
    i_sign_c = v.sc; i_exp_c = v.ec; i_frac_c = v.fc;
    i_sign_x = v.sx; i_exp_x = v.ex; i_frac_x = v.fx;
    i_X_ZERO_CAL = v.xz; i_RESULT_SIGN_FLIP = v.fl;
  endtask
  task automatic clr_pulse();
    @(negedge i_clk); i_flag_clr = 1;
    @(negedge i_clk); i_flag_clr = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    vecs[0]  = '{0, 8'h00, 40'h80_0000_0000, 0, 8'h00, 32'h0, 0, 0, 32'h3F800000, 0, 0};
    vecs[1]  = '{0, 8'h00, 40'h80_0000_0000, 0, 8'h00, 32'h0, 0, 1, 32'hBF800000, 0, 0};
    vecs[2]  = '{1, 8'h05, 40'h12_3456_789A, 0, 8'hFD, 32'h8000_0000, 1, 0, 32'h3E000000, 0, 0};
    vecs[3]  = '{0, 8'h00, 40'h80_0000_8000, 0, 8'h00, 32'h0, 0, 0, 32'h3F800000, 0, 0};
    vecs[4]  = '{0, 8'h00, 40'h80_0001_8000, 0, 8'h00, 32'h0, 0, 0, 32'h3F800002, 0, 0};
    vecs[5]  = '{0, 8'h7F, 40'hFF_FFFF_FFFF, 0, 8'h00, 32'h0, 0, 0, 32'h7F800000, 1, 0};
    vecs[6]  = '{0, 8'h81, 40'h80_0000_0000, 0, 8'h00, 32'h0, 0, 0, 32'h00000000, 0, 1};
    vecs[7]  = '{1, 8'h80, 40'h80_0000_0000, 0, 8'h00, 32'h0, 0, 0, 32'h80000000, 0, 0};
    vecs[8]  = '{0, 8'h05, 40'h40_0000_0000, 0, 8'h00, 32'h0, 0, 0, 32'h00000000, 0, 0};
    vecs[9]  = '{0, 8'h82, 40'h80_0000_0000, 0, 8'h00, 32'h0, 0, 0, 32'h00800000, 0, 0};
    vecs[10] = '{0, 8'h7E, 40'hFF_FFFF_FFFF, 0, 8'h00, 32'h0, 0, 0, 32'h7F000000, 0, 0};
    vecs[11] = '{1, 8'h01, 40'hC0_0000_0000, 0, 8'h00, 32'h0, 0, 0, 32'hC0400000, 0, 0};
    vecs[12] = '{0, 8'h81, 40'hFF_FFFF_FFFF, 0, 8'h00, 32'h0, 0, 0, 32'h00800000, 0, 0};
    vecs[13] = '{0, 8'h10, 40'h80_0000_0000, 1, 8'h00, 32'hC000_0000, 1, 1, 32'h3FC00000, 0, 0};
    #12;
    chk("rst_valid", o_valid, 0);
    chk("rst_result", o_result, 0);
    chk("rst_ovf", o_flag_ovf, 0);
    chk("rst_uf", o_flag_uf, 0);
    chk("rst_ready", o_ready, 1);
    @(negedge i_clk); i_rstn = 1;
    for (int i = 0; i < NV; i++) begin
      clr_pulse();
      drive(vecs[i]); i_valid = 1;
      chk($sformatf("v%0d_ready", i), o_ready, 1);
      @(negedge i_clk); i_valid = 0;
      chk($sformatf("v%0d_early_valid", i), o_valid, 0);
      @(negedge i_clk);
      chk($sformatf("v%0d_valid", i), o_valid, 1);
      chk($sformatf("v%0d_result", i), o_result, vecs[i].res);
      chk($sformatf("v%0d_ovf", i), o_flag_ovf, vecs[i].ovf);
      chk($sformatf("v%0d_uf", i), o_flag_uf, vecs[i].uf);
    end
    clr_pulse();
    drive(vecs[5]); i_valid = 1;
    @(negedge i_clk); drive(vecs[6]);
    @(negedge i_clk); drive(vecs[0]);
    @(negedge i_clk); i_valid = 0;
    repeat (4) @(negedge i_clk);
    chk("sticky_ovf", o_flag_ovf, 1);
    chk("sticky_uf", o_flag_uf, 1);
    chk("sticky_last_result", o_result, 32'h3F800000);
    clr_pulse();
    chk("clr_ovf", o_flag_ovf, 0);
    chk("clr_uf", o_flag_uf, 0);
    @(negedge i_clk); drive(vecs[5]); i_valid = 1;
    @(negedge i_clk); i_valid = 0; i_flag_clr = 1;
    @(negedge i_clk); i_flag_clr = 0;
    chk("clrprio_valid", o_valid, 1);
    chk("clrprio_result", o_result, 32'h7F800000);
    chk("clrprio_ovf", o_flag_ovf, 0);
    bp[0] = vecs[0]; bp[1] = vecs[11]; bp[2] = vecs[4];
    @(negedge i_clk); i_ready = 0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge i_clk);
      if (idx < 3) begin drive(bp[idx]); i_valid = 1; end else i_valid = 0;
      #1 acc = i_valid && o_ready;
      @(posedge i_clk);
      if (acc) idx++;
    end
    @(negedge i_clk);
    chk("bp_accepted", idx, 2);
    chk("bp_ready", o_ready, 0);
    chk("bp_valid", o_valid, 1);
    chk("bp_result", o_result, 32'h3F800000);
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      chk($sformatf("bp_hold%0d", c), o_result, 32'h3F800000);
    end
    for (int c = 0; c < 20 && got.size() < 3; c++) begin
      @(negedge i_clk); i_ready = 1;
      if (idx < 3) begin drive(bp[idx]); i_valid = 1; end else i_valid = 0;
      #1 acc = i_valid && o_ready;
      if (o_valid) got.push_back(o_result);
      @(posedge i_clk);
      if (acc) idx++;
    end
    @(negedge i_clk); i_valid = 0;
    chk("bp_total_accepted", idx, 3);
    chk("bp_count", got.size(), 3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("bp_order%0d", k), k < got.size() ? got[k] : 32'hxxxxxxxx, bp[k].res);
    clr_pulse();
    i_ready = 0; drive(vecs[5]); i_valid = 1;
    @(negedge i_clk); drive(vecs[0]);
    @(negedge i_clk); i_valid = 0;
    chk("rs_pre_valid", o_valid, 1);
    chk("rs_pre_ovf", o_flag_ovf, 1);
    chk("rs_pre_ready", o_ready, 0);
    #2 i_rstn = 0;
    #1;
    chk("rs_valid", o_valid, 0);
    chk("rs_ovf", o_flag_ovf, 0);
    chk("rs_uf", o_flag_uf, 0);
    chk("rs_result", o_result, 0);
    chk("rs_ready", o_ready, 1);
    @(negedge i_clk); i_rstn = 1; i_ready = 1;
    repeat (3) @(negedge i_clk);
    chk("rs_discard_valid", o_valid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sincos_result_pack.md
Name: sincos_result_pack

Overview:
- Final output stage of the fsincos datapath; sits downstream of the last FMA stage.
- Consumes the FMA result (internal sign/exp/frac format), the bypassed D-or-X operand and the control flags.
- Selects the X-zero shortcut or the FMA result, applies the result sign flip, rounds to IEEE-754 binary32, and delivers it over a valid/ready interface.
- Keeps sticky overflow/underflow status.

Parameters:
- FRAC_WIDTH, 40, internal mantissa width; legal range 26..64.
- EXP_WIDTH, 8, internal signed exponent width; fixed at 8.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  asynchronous active-low reset
- i_valid  in  1  input beat present
- o_ready  out  1  block accepts input this cycle
- i_sign_c  in  1  FMA result sign
- i_exp_c  in  EXP_WIDTH  FMA result exponent, two's complement
- i_frac_c  in  FRAC_WIDTH  FMA result mantissa
- i_sign_x  in  1  bypassed X sign
- i_exp_x  in  8  bypassed X exponent
- i_frac_x  in  32  bypassed X mantissa (top 32 bits of internal format)
- i_X_ZERO_CAL  in  1  1: result is X (small-argument path)
- i_RESULT_SIGN_FLIP  in  1  invert the final sign
- o_valid  out  1  o_result valid
- i_ready  in  1  downstream accepts
- o_result  out  32  IEEE-754 binary32 result
- i_flag_clr  in  1  clear sticky flags
- o_flag_ovf  out  1  sticky: a result saturated to infinity
- o_flag_uf  out  1  sticky: a nonzero result flushed to zero

Behaviour:
- Reset (i_clk clock; i_rstn asynchronous, active-low): o_valid=0, o_result=0, o_flag_ovf=0, o_flag_uf=0, all stage valids=0. A reset mid-operation discards all in-flight beats.
- Internal format: value = (-1)^s * (frac / 2^(FRAC_WIDTH-1)) * 2^exp. frac MSB is the leading one. exp=-128 or frac MSB=0 encodes zero.
- Two-stage pipeline, S1 then S2; S2 is the output register.
- Accept on i_valid && o_ready.
- o_ready = !s1_v || s1_adv, where s1_adv = s1_v && (!o_valid || i_ready). o_ready is combinational.
- S1, on accept:
  - If i_X_ZERO_CAL: operand = {i_sign_x, i_exp_x, i_frac_x zero-padded to FRAC_WIDTH}.
  - Otherwise: operand = the c-path inputs.
  - sign ^= i_RESULT_SIGN_FLIP.
- S2, on s1_adv: round and pack.
  - Zero input: result = {sign, 31'b0}, no flag.
  - be = exp + 127, computed 10-bit signed.
  - Mantissa m = frac[FW-2:FW-24]; guard g = frac[FW-25]; sticky st = OR(frac[FW-26:0]).
  - Round to nearest even: increment when g && (st || m[0]).
  - If the increment carries out: m=0, be+1.
  - be <= 0 (nonzero input): result = {sign, 31'b0}, set uf.
  - be >= 255 after rounding: result = {sign, 8'hFF, 23'b0}, set ovf.
  - Otherwise: {sign, be[7:0], m}.
- Latency: 2 cycles from accept to o_valid when unstalled; throughput 1 beat/cycle.
- Handshake:
  - o_result/o_valid hold stable while o_valid && !i_ready.
  - Beats are never dropped or duplicated; order is preserved.
  - At most 2 beats are in flight.
- Stall: with S1 and S2 both full and i_ready=0, o_ready=0.
- Simultaneous i_ready and accept when full: S2 takes S1, S1 takes the input (full throughput).
- Sticky flags set when the S2 register loads a flagging result.
  - i_flag_clr has priority over a set in the same cycle.
  - Flags are independent of the handshake.

Decomposition:
- Shared package holds:
  - IEEE constants BIAS=127, EXP_MAX=255.
  - The internal zero exponent -128.
  - A typedef for the internal float (sign/exp/frac) and for binary32 fields.
- One natural sub-module: fp_round_pack. It is combinational (internal float in; binary32 plus ovf/uf out) and is reusable by the other output paths.

Test Plan:
- sign0, exp0, frac_c=40'h80_0000_0000, flags 0 -> o_result=32'h3F800000 two cycles after accept; same with RESULT_SIGN_FLIP=1 -> 32'hBF800000.
- X_ZERO_CAL=1, exp_x=-3, frac_x=32'h8000_0000, c inputs garbage -> 32'h3E000000.
- Tie rounding:
  - frac_c=40'h80_0000_8000, exp0 -> 32'h3F800000 (tie, even, no increment).
  - frac_c=40'h80_0001_8000 -> 32'h3F800002.
- Overflow/underflow:
  - exp=127, frac all ones -> 32'h7F800000, ovf=1.
  - exp=-127, frac=40'h80_0000_0000 -> 32'h00000000, uf=1.
  - Both flags stay set until i_flag_clr.
  - exp=-128 -> zero with no flag.
- Backpressure:
  - i_ready=0, drive 3 back-to-back beats -> 2 accepted, o_ready=0, o_result stable.
  - Release i_ready -> beats emerge in order, no loss.
  - Assert i_rstn=0 mid-stall -> o_valid=0 and flags=0 immediately.
